// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART boot loader: FSM encodings and protocol constants.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        GET_LEN,
        GET_B2,
        GET_B1,
        GET_B0,
        WRITE,
        DONE,
        ERR
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int BYTES_PER_INSTR = 3;

    // A length byte of zero requests the full 2^ADDR_W instruction memory.
    localparam bit LEN_ZERO_MEANS_MAX = 1'b1;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
module uart_rx_byte
    import prog_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       stop_ok_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic             fall;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             stop_ok_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall = prev_q & ~sync2_q;

    // Returning to idle straight after the stop sample lets back-to-back frames be caught.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            stop_ok_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (fall) begin
                        cnt_q   <= '0;
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {sync2_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        valid_q   <= 1'b1;
                        stop_ok_q <= sync2_q;
                        state_q   <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign rx_byte_o    = shift_q;
    assign stop_ok_o    = stop_ok_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader top: receives a length-prefixed program over UART and writes it into instruction RAM.
// The CPU reset at system level is expected to be rst | cpu_hold.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               frame_err
);

    localparam int REM_W = ADDR_W + 1;

    logic               byte_valid;
    logic [7:0]         rx_byte;
    logic               stop_ok;

    loader_state_e      state_q;
    logic [REM_W-1:0]   remaining_q;
    logic [REM_W-1:0]   len_count_d;
    logic [INSTR_W-1:0] word_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic               hold_q;
    logic               done_q;
    logic               ferr_q;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx),
        .byte_valid_o (byte_valid),
        .rx_byte_o    (rx_byte),
        .stop_ok_o    (stop_ok)
    );

    always_comb begin
        len_count_d = REM_W'(rx_byte);
        if (LEN_ZERO_MEANS_MAX && rx_byte == 8'd0) begin
            len_count_d = {1'b1, {ADDR_W{1'b0}}};
        end
    end

    // Address and count advance the cycle after the strobe, so both are stable while it is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GET_LEN;
            remaining_q <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            hold_q      <= 1'b1;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (byte_valid && !stop_ok && state_q != DONE) begin
                ferr_q  <= 1'b1;
                state_q <= ERR;
            end else begin
                case (state_q)
                    GET_LEN: begin
                        if (byte_valid) begin
                            remaining_q <= len_count_d;
                            state_q     <= GET_B2;
                        end
                    end
                    GET_B2, GET_B1, GET_B0: begin
                        if (byte_valid) begin
                            word_q <= {word_q[INSTR_W-9:0], rx_byte};
                            case (state_q)
                                GET_B2:  state_q <= GET_B1;
                                GET_B1:  state_q <= GET_B0;
                                default: state_q <= WRITE;
                            endcase
                        end
                    end
                    WRITE: begin
                        we_q    <= 1'b1;
                        state_q <= (remaining_q == REM_W'(1)) ? DONE : GET_B2;
                    end
                    DONE: begin
                        hold_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    default: state_q <= ERR;
                endcase
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader: a byte-level program model predicts every RAM write.
module tb_prog_loader;

    localparam int CLK_FREQ = 600_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               uart_rx;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               cpu_hold;
    logic               load_done;
    logic               frame_err;

    typedef struct {
        int addr;
        int data;
        bit last;
    } wr_t;

    wr_t        expq[$];
    logic [7:0] prog[$];
    int         checks = 0;
    int         errors = 0;

    prog_loader #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected writes come from the protocol rules: word w of the program lands at address w mod 256.
    task automatic modelProgram(input int sent);
        int  n;
        int  words;
        wr_t e;
        n     = (prog[0] == 8'd0) ? 256 : int'(prog[0]);
        words = (sent - 1) / 3;
        if (words > n) words = n;
        for (int w = 0; w < words; w++) begin
            e.addr = w % 256;
            e.data = {8'h00, prog[1 + 3*w], prog[2 + 3*w], prog[3 + 3*w]};
            e.last = (w == n - 1);
            expq.push_back(e);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit goodStop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = goodStop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        if (!goodStop) repeat (CPB) @(negedge clk);
    endtask

    // badIdx selects one byte to send with a low stop bit; -1 sends everything cleanly.
    task automatic applyStimulus(input int count, input int gapMax, input int badIdx);
        for (int i = 0; i < count; i++) begin
            sendByte(prog[i], i != badIdx);
            if (gapMax > 0) repeat ($urandom_range(0, gapMax * CPB)) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (3 * CPB) @(negedge clk);
        checkOutput("scoreboard_drained", expq.size(), 0);
        expq.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_cpu_hold"}, cpu_hold, 1);
        checkOutput({tag, "_imem_we"}, imem_we, 0);
        checkOutput({tag, "_imem_addr"}, imem_addr, 0);
        checkOutput({tag, "_imem_wdata"}, imem_wdata, 0);
        checkOutput({tag, "_load_done"}, load_done, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic doReset(input string tag);
        uart_rx = 1'b1;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        checkReset(tag);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic randomProgram(input int nMax);
        int n;
        n = $urandom_range(1, nMax);
        prog.delete();
        prog.push_back(8'(n));
        for (int i = 0; i < 3 * n; i++) prog.push_back(8'($urandom));
    endtask

    task automatic checkLoaded(input string tag);
        checkOutput({tag, "_load_done"}, load_done, 1);
        checkOutput({tag, "_cpu_hold"}, cpu_hold, 0);
        checkOutput({tag, "_frame_err"}, frame_err, 0);
    endtask

    // Monitor: every strobe is matched against the oldest predicted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = expq.pop_front();
                    checkOutput("write_addr", 32'(imem_addr), e.addr);
                    checkOutput("write_data", 32'(imem_wdata), e.data);
                    checkOutput("hold_during_write", cpu_hold, 1);
                    checkOutput("done_during_write", load_done, 0);
                    if (e.last) begin
                        @(negedge clk);
                        checkOutput("load_done_after_last", load_done, 1);
                        checkOutput("cpu_hold_after_last", cpu_hold, 0);
                        checkOutput("we_after_last", imem_we, 0);
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] directed two-word program");
        prog = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        modelProgram(prog.size());
        applyStimulus(prog.size(), 0, -1);
        settle();
        checkLoaded("two_word");

        $display("[TB] bytes after done are ignored");
        prog = '{8'h01, 8'(32'($urandom)), 8'(32'($urandom)), 8'(32'($urandom))};
        applyStimulus(prog.size(), 1, -1);
        settle();
        checkLoaded("after_done");

        $display("[TB] random program");
        doReset("reset_random");
        randomProgram(12);
        modelProgram(prog.size());
        applyStimulus(prog.size(), 2, -1);
        settle();
        checkLoaded("random");

        $display("[TB] bad stop bit on second data byte");
        doReset("reset_ferr");
        randomProgram(4);
        applyStimulus(prog.size(), 1, 2);
        settle();
        checkOutput("ferr_frame_err", frame_err, 1);
        checkOutput("ferr_cpu_hold", cpu_hold, 1);
        checkOutput("ferr_load_done", load_done, 0);
        doReset("reset_after_ferr");
        randomProgram(6);
        modelProgram(prog.size());
        applyStimulus(prog.size(), 1, -1);
        settle();
        checkLoaded("reload");

        $display("[TB] short glitch while idle");
        doReset("reset_glitch");
        @(negedge clk);
        uart_rx = 1'b0;
        #15;
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch_frame_err", frame_err, 0);
        checkOutput("glitch_cpu_hold", cpu_hold, 1);
        randomProgram(6);
        modelProgram(prog.size());
        applyStimulus(prog.size(), 1, -1);
        settle();
        checkLoaded("after_glitch");

        $display("[TB] reset mid-program");
        doReset("reset_mid_pre");
        randomProgram(1);
        prog[0] = 8'h02;
        for (int i = 0; i < 3; i++) prog.push_back(8'(32'($urandom)));
        modelProgram(4);
        applyStimulus(4, 0, -1);
        settle();
        doReset("reset_mid");
        randomProgram(1);
        modelProgram(prog.size());
        applyStimulus(prog.size(), 0, -1);
        settle();
        checkLoaded("fresh_single");

        $display("[TB] full 256-word program");
        doReset("reset_full");
        prog.delete();
        prog.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 3; k++) prog.push_back(8'(i));
        end
        modelProgram(prog.size());
        applyStimulus(prog.size(), 0, -1);
        settle();
        checkLoaded("full");
        checkOutput("full_addr_wrapped", imem_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
